// File: rtl/rf_commit_ctrl.sv
// Purpose: retires ROB head entries into the RegFile commit port; runs restore/flush on exceptions.
// Latency: commit_* outputs are registered, 1 cycle after the rob_valid && rob_ready transfer.
// Backpressure: rob_ready is low during reset and outside RUN (RESTORE/DRAIN); entries are held by the ROB.
// Optional: define RF_COMMIT_PERF_CNT_EN to build the retired-instruction counter (else retire_count = 0).
module rf_commit_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 6,
    parameter int RF_REG_HI     = 32,
    parameter int FLUSH_CYCLES  = 2,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rob_valid,
    output logic                     rob_ready,
    input  logic                     rob_dest_en,
    input  logic [RF_ADDR_WIDTH-1:0] rob_dest_addr,
    input  logic [DATA_WIDTH-1:0]    rob_data,
    input  logic                     rob_lo_en,
    input  logic [DATA_WIDTH-1:0]    rob_lo_data,
    input  logic                     rob_exc,
    output logic                     commit_en,
    output logic                     commit_add,
    output logic [RF_ADDR_WIDTH-1:0] commit_addr,
    output logic [DATA_WIDTH-1:0]    commit_data,
    output logic                     commit_lo_en,
    output logic [DATA_WIDTH-1:0]    commit_lo_data,
    output logic                     commit_restore,
    output logic                     flush_out,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     retire_count
);

    // Drain counter only needs to hold FLUSH_CYCLES-1.
    localparam int DCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    // Reject configurations that cannot work: zero-length flush or HI outside the RegFile.
    if (FLUSH_CYCLES < 1 || RF_REG_HI >= (1 << RF_ADDR_WIDTH)) begin : g_bad_param
        $error("rf_commit_ctrl: illegal FLUSH_CYCLES or RF_REG_HI");
    end

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_RESTORE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           xfer;

    assign rob_ready = (state_q == S_RUN) && !rst;
    assign xfer      = rob_valid && rob_ready;

    // Flush is held through RESTORE and while the drain counter is non-zero,
    // so it is high for exactly FLUSH_CYCLES cycles after the exception.
    assign flush_out = (state_q == S_RESTORE) || ((state_q == S_DRAIN) && (drain_cnt_q != '0));
    assign busy      = (state_q != S_RUN);

    // State and drain-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state: exception enters RESTORE, then DRAIN counts down back to RUN.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_RUN: begin
                if (xfer && rob_exc) state_d = S_RESTORE;
            end
            S_RESTORE: begin
                if (FLUSH_CYCLES == 1) begin
                    state_d = S_RUN;
                end else begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = DCW'(FLUSH_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) state_d = S_RUN;
                else                   drain_cnt_d = drain_cnt_q - 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Commit port: single-cycle pulses registered from the accepted entry; $zero never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_en      <= 1'b0;
            commit_add     <= 1'b0;
            commit_addr    <= '0;
            commit_data    <= '0;
            commit_lo_en   <= 1'b0;
            commit_lo_data <= '0;
            commit_restore <= 1'b0;
        end else begin
            commit_en      <= 1'b0;
            commit_add     <= 1'b0;
            commit_lo_en   <= 1'b0;
            commit_restore <= 1'b0;
            if (xfer && !rob_exc) begin
                commit_en      <= rob_dest_en && (rob_dest_addr != '0);
                commit_add     <= 1'b1;
                commit_addr    <= rob_dest_addr;
                commit_data    <= rob_data;
                commit_lo_en   <= rob_lo_en;
                commit_lo_data <= rob_lo_data;
            end else if (xfer && rob_exc) begin
                commit_restore <= 1'b1;
            end
        end
    end

`ifdef RF_COMMIT_PERF_CNT_EN
    // Retired-instruction counter; excepting entries are not counted, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)                   retire_count <= '0;
        else if (xfer && !rob_exc) retire_count <= retire_count + 1'b1;
    end
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_rf_commit_ctrl.sv
// Purpose: directed self-checking bench for rf_commit_ctrl (FLUSH_CYCLES = 2).
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit after the next posedge.
// Backpressure: rob_valid is held during RESTORE/DRAIN to confirm it is ignored.
module tb_rf_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rob_valid, rob_ready, rob_dest_en, rob_lo_en, rob_exc;
    logic [5:0]  rob_dest_addr;
    logic [31:0] rob_data, rob_lo_data;
    logic        commit_en, commit_add, commit_lo_en, commit_restore, flush_out, busy;
    logic [5:0]  commit_addr;
    logic [31:0] commit_data, commit_lo_data, retire_count;

    int n_chk  = 0;
    int n_pass = 0;
    int sw_cnt = 0;

    rf_commit_ctrl dut (
        .clk(clk), .rst(rst),
        .rob_valid(rob_valid), .rob_ready(rob_ready),
        .rob_dest_en(rob_dest_en), .rob_dest_addr(rob_dest_addr), .rob_data(rob_data),
        .rob_lo_en(rob_lo_en), .rob_lo_data(rob_lo_data), .rob_exc(rob_exc),
        .commit_en(commit_en), .commit_add(commit_add), .commit_addr(commit_addr),
        .commit_data(commit_data), .commit_lo_en(commit_lo_en), .commit_lo_data(commit_lo_data),
        .commit_restore(commit_restore), .flush_out(flush_out), .busy(busy),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef RF_COMMIT_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic v, input logic de, input logic [5:0] a, input logic [31:0] d,
                             input logic le, input logic [31:0] ld, input logic ex);
        rob_valid = v; rob_dest_en = de; rob_dest_addr = a; rob_data = d;
        rob_lo_en = le; rob_lo_data = ld; rob_exc = ex;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_entry(1'b1, 1'b1, 6'd3, 32'h1, 1'b1, 32'h2, 1'b0);
        tick(); tick();
        n_chk++; if (rob_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", rob_ready); else n_pass++;
        n_chk++; if ({commit_en, commit_add, commit_lo_en, commit_restore, flush_out, busy} !== 6'b0)
            $display("FAIL reset_strobes got %b exp 000000", {commit_en, commit_add, commit_lo_en, commit_restore, flush_out, busy}); else n_pass++;
        n_chk++; if (retire_count !== 32'd0) $display("FAIL reset_count got %0d exp 0", retire_count); else n_pass++;
        n_chk++; if (commit_data !== 32'd0) $display("FAIL reset_data got %h exp 0", commit_data); else n_pass++;
        set_entry(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        sw_cnt = 0;
        #1;
        n_chk++; if (rob_ready !== 1'b1) $display("FAIL post_reset_ready got %b exp 1", rob_ready); else n_pass++;
    endtask

    task automatic test_normal();
        set_entry(1'b1, 1'b1, 6'd1, 32'h12345678, 1'b0, 32'h0, 1'b0);
        tick();
        set_entry(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        sw_cnt++;
        n_chk++; if (commit_en !== 1'b1 || commit_add !== 1'b1) $display("FAIL normal_strobes got en=%b add=%b exp 1 1", commit_en, commit_add); else n_pass++;
        n_chk++; if (commit_addr !== 6'd1 || commit_data !== 32'h12345678) $display("FAIL normal_payload got %0d/%h exp 1/12345678", commit_addr, commit_data); else n_pass++;
        n_chk++; if (retire_count !== exp_cnt(sw_cnt)) $display("FAIL normal_count got %0d exp %0d", retire_count, exp_cnt(sw_cnt)); else n_pass++;
        tick();
        n_chk++; if (commit_en !== 1'b0 || commit_add !== 1'b0) $display("FAIL normal_one_cycle got en=%b add=%b exp 0 0", commit_en, commit_add); else n_pass++;
    endtask

    task automatic test_zero();
        set_entry(1'b1, 1'b1, 6'd0, 32'hffffffff, 1'b0, 32'h0, 1'b0);
        tick();
        set_entry(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        sw_cnt++;
        n_chk++; if (commit_en !== 1'b0 || commit_add !== 1'b1) $display("FAIL zero_strobes got en=%b add=%b exp 0 1", commit_en, commit_add); else n_pass++;
        n_chk++; if (retire_count !== exp_cnt(sw_cnt)) $display("FAIL zero_count got %0d exp %0d", retire_count, exp_cnt(sw_cnt)); else n_pass++;
        tick();
    endtask

    task automatic test_hilo();
        set_entry(1'b1, 1'b1, 6'd32, 32'h10203040, 1'b1, 32'h50607080, 1'b0);
        tick();
        set_entry(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        sw_cnt++;
        n_chk++; if (commit_en !== 1'b1 || commit_lo_en !== 1'b1) $display("FAIL hilo_strobes got en=%b lo=%b exp 1 1", commit_en, commit_lo_en); else n_pass++;
        n_chk++; if (commit_addr !== 6'd32 || commit_data !== 32'h10203040) $display("FAIL hilo_hi got %0d/%h exp 32/10203040", commit_addr, commit_data); else n_pass++;
        n_chk++; if (commit_lo_data !== 32'h50607080) $display("FAIL hilo_lo got %h exp 50607080", commit_lo_data); else n_pass++;
        n_chk++; if (retire_count !== exp_cnt(sw_cnt)) $display("FAIL hilo_count got %0d exp %0d", retire_count, exp_cnt(sw_cnt)); else n_pass++;
        tick();
        n_chk++; if (commit_lo_en !== 1'b0) $display("FAIL hilo_lo_one_cycle got %b exp 0", commit_lo_en); else n_pass++;
    endtask

    task automatic test_exception();
        // rob_valid stays high across RESTORE/DRAIN; those cycles must not transfer.
        set_entry(1'b1, 1'b1, 6'd5, 32'habcdef00, 1'b0, 32'h0, 1'b1);
        tick();
        n_chk++; if ({commit_restore, flush_out, busy, rob_ready} !== 4'b1110) $display("FAIL exc_c1 got rst/fl/busy/rdy=%b exp 1110", {commit_restore, flush_out, busy, rob_ready}); else n_pass++;
        n_chk++; if ({commit_en, commit_add, commit_lo_en} !== 3'b000) $display("FAIL exc_c1_strobes got %b exp 000", {commit_en, commit_add, commit_lo_en}); else n_pass++;
        n_chk++; if (retire_count !== exp_cnt(sw_cnt)) $display("FAIL exc_count got %0d exp %0d", retire_count, exp_cnt(sw_cnt)); else n_pass++;
        tick();
        n_chk++; if ({commit_restore, flush_out, busy, rob_ready} !== 4'b0110) $display("FAIL exc_c2 got rst/fl/busy/rdy=%b exp 0110", {commit_restore, flush_out, busy, rob_ready}); else n_pass++;
        tick();
        n_chk++; if ({commit_restore, flush_out, busy, rob_ready} !== 4'b0010) $display("FAIL exc_c3 got rst/fl/busy/rdy=%b exp 0010", {commit_restore, flush_out, busy, rob_ready}); else n_pass++;
        n_chk++; if ({commit_en, commit_add} !== 2'b00) $display("FAIL exc_no_commit got %b exp 00", {commit_en, commit_add}); else n_pass++;
        set_entry(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        n_chk++; if ({commit_restore, flush_out, busy, rob_ready} !== 4'b0001) $display("FAIL exc_resume got rst/fl/busy/rdy=%b exp 0001", {commit_restore, flush_out, busy, rob_ready}); else n_pass++;
        n_chk++; if (retire_count !== exp_cnt(sw_cnt)) $display("FAIL exc_count_after got %0d exp %0d", retire_count, exp_cnt(sw_cnt)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333; vals[3] = 32'h44444444;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sw_cnt = 0;
        set_entry(1'b1, 1'b1, 6'd10, vals[0], 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            sw_cnt++;
            if (i < 3) set_entry(1'b1, 1'b1, 6'(11 + i), vals[i+1], 1'b0, 32'h0, 1'b0);
            else       set_entry(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0);
            n_chk++; if (commit_en !== 1'b1 || commit_addr !== 6'(10 + i) || commit_data !== vals[i])
                $display("FAIL b2b_%0d got en=%b %0d/%h exp 1 %0d/%h", i, commit_en, commit_addr, commit_data, 10 + i, vals[i]); else n_pass++;
        end
        n_chk++; if (retire_count !== exp_cnt(4)) $display("FAIL b2b_count got %0d exp %0d", retire_count, exp_cnt(4)); else n_pass++;
        tick();
        n_chk++; if (commit_en !== 1'b0) $display("FAIL b2b_end got %b exp 0", commit_en); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        set_entry(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        set_entry(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        n_chk++; if ({busy, flush_out} !== 2'b11) $display("FAIL drain_entered got busy/fl=%b exp 11", {busy, flush_out}); else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++; if ({rob_ready, commit_en, commit_add, commit_lo_en, commit_restore, flush_out, busy} !== 7'b0)
            $display("FAIL rst_drain_outputs got %b exp 0000000", {rob_ready, commit_en, commit_add, commit_lo_en, commit_restore, flush_out, busy}); else n_pass++;
        n_chk++; if (retire_count !== 32'd0) $display("FAIL rst_drain_count got %0d exp 0", retire_count); else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (rob_ready !== 1'b1) $display("FAIL rst_drain_ready got %b exp 1", rob_ready); else n_pass++;
        tick();
        n_chk++; if ({commit_restore, flush_out, busy} !== 3'b000) $display("FAIL rst_drain_no_restore got %b exp 000", {commit_restore, flush_out, busy}); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        set_entry(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        test_reset();
        test_normal();
        test_zero();
        test_hilo();
        test_exception();
        test_back_to_back();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_commit_ctrl.md
Name: rf_commit_ctrl

Overview:
- Sequences retirement from the reorder buffer head into the register file commit port.
- Accepts one ROB head entry per cycle over a valid/ready handshake and drives commit_en/addr/data, commit_add, commit_lo_en/data and commit_restore.
- When the head entry carries an exception, it runs the restore-and-flush sequence.
- Sits between the ROB and RegFile; it is the only driver of the RegFile commit port.

Parameters:
- DATA_WIDTH, 32, width of committed data.
- RF_ADDR_WIDTH, 6, register file address width (GPRs 0-31 plus HI).
- RF_REG_HI, 32, register file address of HI.
- FLUSH_CYCLES, 2, cycles flush_out stays high after restore (must be >=1).
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rob_valid  in  1  ROB head entry valid
- rob_ready  out  1  controller accepts head entry this cycle
- rob_dest_en  in  1  head entry writes a destination register
- rob_dest_addr  in  RF_ADDR_WIDTH  destination address
- rob_data  in  DATA_WIDTH  destination value
- rob_lo_en  in  1  head entry also writes LO
- rob_lo_data  in  DATA_WIDTH  LO value
- rob_exc  in  1  head entry raised an exception
- commit_en  out  1  RegFile commit strobe
- commit_add  out  1  normal in-order retire marker to RegFile
- commit_addr  out  RF_ADDR_WIDTH  commit address
- commit_data  out  DATA_WIDTH  commit data
- commit_lo_en  out  1  LO commit strobe
- commit_lo_data  out  DATA_WIDTH  LO commit data
- commit_restore  out  1  restore architectural map in RegFile
- flush_out  out  1  pipeline flush request
- busy  out  1  high while in RESTORE or DRAIN
- retire_count  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset: one clock; reset is synchronous and active-high. Sampled on the rising clk edge while rst==1. All outputs, including rob_ready and retire_count, are 0 during reset. State returns to RUN.
- rob_ready is combinational: 1 in RUN when rst==0, otherwise 0.
- A transfer occurs when rob_valid && rob_ready.
- All commit_* outputs are registered and appear in the cycle after the transfer (1-cycle latency). They last exactly one cycle unless another transfer follows back-to-back.

RUN state, transfer with rob_exc==0:
- commit_add=1.
- commit_en = rob_dest_en && rob_dest_addr!=0. Address 0 is never committed.
- commit_addr / commit_data follow the entry; commit_lo_en / commit_lo_data follow rob_lo_en / rob_lo_data.
- HI with LO in the same entry: both strobes in the same cycle.
- retire_count increments by 1 and wraps modulo 2^CNT_WIDTH.

RUN state, transfer with rob_exc==1:
- The entry's data is NOT committed; retire_count is unchanged.
- Next cycle: commit_restore=1, flush_out=1, all other commit_* strobes 0. State goes to RESTORE.

RESTORE state (1 cycle):
- commit_restore drops.
- flush_out stays 1; a down-counter loads FLUSH_CYCLES-1. State goes to DRAIN.
- If FLUSH_CYCLES==1, go directly to RUN with flush_out 0.

DRAIN state:
- flush_out=1 while counter!=0; decrement each cycle.
- When the counter is 0, next cycle returns to RUN with flush_out 0.

Other rules:
- busy=1 in RESTORE and DRAIN.
- No transfer while not in RUN; rob_valid is ignored.
- rst asserted mid-RESTORE/DRAIN aborts the sequence immediately. Outputs are 0 the next cycle; no further restore pulse.
- rob_valid without rob_ready holds entry contents; the ROB keeps them stable until transfer.

Optional Feature:
- Macro: RF_COMMIT_PERF_CNT_EN.
- Defined: retire_count counter as specified.
- Undefined: counter logic is omitted and retire_count is constant 0.
- All other behaviour is identical either way.

Test Plan:
- Normal commit: transfer {dest_en=1, addr=1, data=32'h12345678, exc=0} -> next cycle commit_en=1, commit_add=1, commit_addr=1, commit_data=32'h12345678, retire_count=1.
- $zero: transfer {dest_en=1, addr=0, data=32'hffffffff} -> commit_en=0, commit_add=1, retire_count increments.
- HI/LO: transfer {addr=RF_REG_HI, data=32'h10203040, lo_en=1, lo_data=32'h50607080} -> commit_en=1 and commit_lo_en=1 in the same cycle with those values.
- Exception, FLUSH_CYCLES=2: transfer with exc=1, data=32'habcdef00 ->
  - commit_en=0, commit_restore=1 for exactly 1 cycle;
  - flush_out=1 for 2 cycles; rob_ready=0 for 3 cycles;
  - retire_count unchanged; RUN resumes after.
- Back-to-back: rob_valid held 1 for 4 entries -> 4 consecutive commit_en cycles, retire_count=4, no bubbles.
- Reset mid-DRAIN: rst=1 during DRAIN -> all outputs 0 next cycle; after rst drops, rob_ready=1 immediately.
